// File: rtl/am_env_demod.sv
// AM envelope demodulator: full-wave rectify offset-binary ADC samples, then accumulate-and-dump over 2^WIN_LOG2 samples.
// Optional macro AM_ENV_DEMOD_SCALE_EN rescales the rectified mean to peak amplitude (x201/128) with one extra stage.
module am_env_demod #(
  parameter int unsigned MID      = 2047,
  parameter int unsigned WIN_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        adc_valid,
  input  logic [11:0] adc_data,
  output logic [11:0] env_out,
  output logic        env_valid,
  output logic        env_clip
);

  localparam int unsigned AW = 11 + WIN_LOG2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DUMP  = 2'd2;

  logic [11:0]         mid_c;
  logic [11:0]         diff_c;
  logic [10:0]         mag_c;
  logic                s1_valid;
  logic [10:0]         s1_mag;
  logic                s1_clip;
  logic [1:0]          state;
  logic [AW-1:0]       acc;
  logic [WIN_LOG2-1:0] cnt;
  logic                sticky;
  logic [10:0]         mean_c;

  assign mid_c = 12'(MID);

  // Rectify about the midpoint; 4095 would give 2048, so saturate to 11 bits.
  always_comb begin
    diff_c = '0;
    mag_c  = '0;
    if (adc_data >= mid_c) diff_c = adc_data - mid_c;
    else                   diff_c = mid_c - adc_data;
    mag_c = (diff_c > 12'd2047) ? 11'd2047 : diff_c[10:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mag   <= '0;
      s1_clip  <= 1'b0;
    end else begin
      s1_valid <= adc_valid;
      if (adc_valid) begin
        s1_mag  <= mag_c;
        s1_clip <= (adc_data == 12'd0) || (adc_data == 12'd4095);
      end
    end
  end

  assign mean_c = acc[AW-1:WIN_LOG2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
    end else begin
      case (state)
        S_ACCUM: begin
          if (!en) begin
            state  <= S_IDLE;
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
          end else if (s1_valid) begin
            acc    <= acc + AW'(s1_mag);
            cnt    <= cnt + 1'b1;
            sticky <= sticky | s1_clip;
            if (cnt == '1) state <= S_DUMP;
          end
        end
        S_DUMP: begin
          // A sample arriving during the dump opens the next window.
          if (en && s1_valid) begin
            acc    <= AW'(s1_mag);
            cnt    <= WIN_LOG2'(1);
            sticky <= s1_clip;
          end else begin
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
          end
          state <= en ? S_ACCUM : S_IDLE;
        end
        default: begin
          acc    <= '0;
          cnt    <= '0;
          sticky <= 1'b0;
          if (en) state <= S_ACCUM;
          else    state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef AM_ENV_DEMOD_SCALE_EN
  logic        m_valid;
  logic [10:0] m_mean;
  logic        m_clip;
  logic [11:0] scaled_c;

  always_comb begin
    scaled_c = 12'((19'(m_mean) * 19'd201) >> 7);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid   <= 1'b0;
      m_mean    <= '0;
      m_clip    <= 1'b0;
      env_valid <= 1'b0;
      env_out   <= '0;
      env_clip  <= 1'b0;
    end else begin
      m_valid   <= (state == S_DUMP);
      if (state == S_DUMP) begin
        m_mean <= mean_c;
        m_clip <= sticky;
      end
      env_valid <= m_valid;
      if (m_valid) begin
        env_out  <= (scaled_c > 12'd2047) ? 12'd2047 : scaled_c;
        env_clip <= m_clip;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env_valid <= 1'b0;
      env_out   <= '0;
      env_clip  <= 1'b0;
    end else begin
      env_valid <= (state == S_DUMP);
      if (state == S_DUMP) begin
        env_out  <= {1'b0, mean_c};
        env_clip <= sticky;
      end
    end
  end
`endif

endmodule

// File: tb/tb_am_env_demod.sv
// Self-checking bench for am_env_demod: table of constant/alternating windows plus reset, abort and dump-cycle sequences.
module tb_am_env_demod;

  localparam int WIN = 64;
`ifdef AM_ENV_DEMOD_SCALE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        adc_valid;
  logic [11:0] adc_data;
  logic [11:0] env_out;
  logic        env_valid;
  logic        env_clip;

  am_env_demod #(.MID(2047), .WIN_LOG2(6)) dut (
    .clk(clk), .rst(rst), .en(en), .adc_valid(adc_valid), .adc_data(adc_data),
    .env_out(env_out), .env_valid(env_valid), .env_clip(env_clip)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int env; int clip; int due; } exp_t;
  typedef struct { int a; int b; int gap; int env; int clip; } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int n_cmp = 0;
  int n_err = 0;

  function automatic int scale(input int raw);
`ifdef AM_ENV_DEMOD_SCALE_EN
    int s;
    s = (raw * 201) >> 7;
    return (s > 2047) ? 2047 : s;
`else
    return raw;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input int d);
    @(negedge clk);
    adc_valid = v;
    adc_data  = 12'(d);
  endtask

  // Sends one full window; the expectation is queued when the last sample goes out.
  task automatic run_window(input int a, input int b, input int gap, input int env, input int clip);
    exp_t e;
    for (int i = 0; i < WIN; i++) begin
      drive(1'b1, (i % 2 == 1) ? b : a);
      if (i == WIN - 1) begin
        e.env  = scale(env);
        e.clip = clip;
        e.due  = cyc + 1 + LAT;
        sb.push_back(e);
      end
      for (int g = 0; g < gap; g++) drive(1'b0, 2748);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && sb.size() != 0; k++) drive(1'b0, 0);
    chk("drain_pending", sb.size(), 0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (env_valid) begin
        if (sb.size() == 0) chk("unexpected_env_valid", 1, 0);
        else begin
          e = sb.pop_front();
          chk("env_out", int'(env_out), e.env);
          chk("env_clip", int'(env_clip), e.clip);
          chk("latency_cycle", cyc, e.due);
        end
      end else if (sb.size() != 0 && cyc >= sb[0].due) begin
        e = sb.pop_front();
        chk("missing_env_valid", 0, 1);
      end
    end
  end

  initial begin
    vecs[0] = '{a: 2047, b: 2047, gap: 0, env: 0,    clip: 0};
    vecs[1] = '{a: 2047, b: 2047, gap: 0, env: 0,    clip: 0};
    vecs[2] = '{a: 3047, b: 1047, gap: 0, env: 1000, clip: 0};
    vecs[3] = '{a: 0,    b: 4095, gap: 0, env: 2047, clip: 1};
    vecs[4] = '{a: 2547, b: 2547, gap: 0, env: 500,  clip: 0};
    vecs[5] = '{a: 2000, b: 2100, gap: 0, env: 50,   clip: 0};
    vecs[6] = '{a: 4094, b: 1,    gap: 0, env: 2046, clip: 0};
    vecs[7] = '{a: 2147, b: 2147, gap: 2, env: 100,  clip: 0};

    rst = 1'b1; en = 1'b0; adc_valid = 1'b0; adc_data = '0;
    #3;
    chk("reset_env_out", int'(env_out), 0);
    chk("reset_env_valid", int'(env_valid), 0);
    chk("reset_env_clip", int'(env_clip), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    for (int v = 0; v < 8; v++)
      run_window(vecs[v].a, vecs[v].b, vecs[v].gap, vecs[v].env, vecs[v].clip);
    drain();

    // Abort after 30 samples; samples seen with en low must not leak into the next window.
    for (int i = 0; i < 30; i++) drive(1'b1, 4000);
    @(negedge clk);
    en = 1'b0; adc_valid = 1'b1; adc_data = 12'd4000;
    for (int i = 0; i < 4; i++) drive(1'b1, 4000);
    chk("hold_env_out_abort", int'(env_out), scale(100));
    chk("hold_env_valid_abort", int'(env_valid), 0);
    @(negedge clk);
    en = 1'b1; adc_valid = 1'b0;
    drive(1'b0, 0);
    run_window(1047, 1047, 0, 1000, 0);
    drain();

    // en drops during the dump cycle: output still appears, then idle.
    run_window(2000, 2100, 0, 50, 0);
    drive(1'b0, 0);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 4095);
    @(negedge clk);
    en = 1'b1; adc_valid = 1'b0;
    drive(1'b0, 0);
    run_window(3047, 1047, 0, 1000, 0);
    drain();

    // Asynchronous reset mid-window, after a clipped window left env_clip high.
    run_window(0, 4095, 0, 2047, 1);
    drain();
    for (int i = 0; i < 20; i++) drive(1'b1, 3047);
    @(negedge clk);
    adc_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_env_out", int'(env_out), 0);
    chk("async_rst_env_valid", int'(env_valid), 0);
    chk("async_rst_env_clip", int'(env_clip), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_window(2147, 2147, 0, 100, 0);
    drain();

    repeat (5) drive(1'b0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/am_env_demod.md
Name: am_env_demod

Overview:
- AM envelope demodulator for the receive path; the counterpart of the carrier×modulation DAC multiplier on the transmit side.
- Takes 12-bit offset-binary ADC samples centred at 2047 and full-wave rectifies them about the midpoint.
- Averages the rectified magnitude over a fixed window of samples (accumulate-and-dump).
- Emits one 12-bit envelope value per window with a single-cycle valid strobe, plus a clip flag.

Parameters:
- MID, 2047, offset-binary midpoint (zero level) of the ADC code.
- WIN_LOG2, 6, log2 of window length; window = 2^WIN_LOG2 valid samples (64). Legal range 1..10.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  demodulator enable; low aborts any window in progress
- adc_valid  in  1  sample strobe; adc_data is sampled only when high
- adc_data  in  12  ADC sample, offset binary
- env_out  out  12  window-averaged envelope magnitude, unsigned, 0..2047
- env_valid  out  1  one-cycle pulse when env_out is updated
- env_clip  out  1  qualified by env_valid; 1 if any sample in the window was 0 or 4095

Behaviour:
- Reset: one clock; rst is asynchronous and active-high, and asserting it clears all state immediately without waiting for clk.
  - env_out=0, env_valid=0, env_clip=0.
  - Accumulator, sample counter and clip sticky cleared; FSM in IDLE.
- Stage 1 (registered, on each edge with adc_valid=1):
  - mag = (adc_data >= MID) ? adc_data-MID : MID-adc_data.
  - mag saturates to 2047 (11 bits); adc_data=4095 gives 2047, not 2048.
  - Stage 1 also registers a valid bit and clip bit = (adc_data==0 || adc_data==4095).
- Stage 2: accumulator width 11+WIN_LOG2 bits. Overflow is impossible by construction and no wrap is permitted.
- FSM states:
  - IDLE: accumulator, counter and clip sticky held at 0; stage-1 valids ignored. en=1 → ACCUM.
  - ACCUM: on each stage-1 valid, acc += mag, cnt += 1, clip sticky |= clip bit. When the valid being accumulated is sample number 2^WIN_LOG2 → DUMP.
  - DUMP (one cycle): env_out = (acc+mag_last) >> WIN_LOG2, env_clip = sticky, env_valid = 1. Accumulator, counter and sticky then restart at 0.
    - If a stage-1 valid coincides with the DUMP cycle, it becomes sample 1 of the next window (acc=mag, cnt=1, sticky=clip bit). No sample is lost.
    - Next state: ACCUM if en=1, else IDLE.
- Latency: env_valid is high in the cycle following the 2nd rising edge after the edge that captures the last window sample.
- Throughput: adc_valid may be high every cycle; gaps are allowed and only valid samples are counted.
- en deasserted in ACCUM: the partial window is discarded and the state goes to IDLE next edge. No env_valid is produced; env_out/env_clip hold their last values.
  - On re-enable, a full new window is required before the next output.
- en deasserted in the DUMP cycle: the output is still produced, then the FSM goes to IDLE.
- env_out and env_clip hold between strobes. env_valid is never high for two consecutive cycles unless WIN_LOG2=1 and adc_valid is continuous.
- adc_valid while en=0 has no effect beyond stage 1.

Optional Feature:
- Macro: AM_ENV_DEMOD_SCALE_EN.
- Defined:
  - The mean is corrected from rectified-average to peak amplitude: env_out = min(2047, (mean*201)>>7), i.e. ≈π/2.
  - Adds one register stage, so env_valid latency becomes 3 edges.
- Undefined: env_out = raw mean with 2-edge latency and no multiplier inferred.

Test Plan:
1. Reset check: assert rst asynchronously mid-window after 20 samples → env_out=0, env_valid=0 and env_clip=0 immediately. After release with en=1, the first env_valid comes only after 64 new samples.
2. Constant adc_data=2047, en=1, adc_valid continuous → env_valid every 64 cycles, env_out=0, env_clip=0.
3. Alternating adc_data 3047/1047, continuous → env_out=1000 (1570 with AM_ENV_DEMOD_SCALE_EN). Latency measured at exactly 2 edges (3 with macro) after the last sample.
4. Alternating 0/4095 → mag 2047 each (saturated) → env_out=2047, env_clip=1. The following window of constant 2547 → env_out=500, env_clip=0.
5. Sparse adc_valid (1 in 3 cycles), adc_data=2147 → env_valid after every 64 valid samples (192 cycles), env_out=100.
6. en dropped after 30 samples, re-raised 5 cycles later → no env_valid for the aborted window; next env_valid after 64 further valid samples with env_out computed only from those samples.
